// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the memory bus arbiter:
//               access size encodings, FSM state and port identifiers,
//               wait-counter width and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  // Wait counter width; region wait states are limited to 0..15
  localparam int CNT_W = 4;

  // Access size encodings shared by requesters and the RAM
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // True when the low address bits are not aligned to the access size
  function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE:  bad = 1'b0;
      SZ_HALF:  bad = (lo[0] != 1'b0);
      SZ_WORD:  bad = (lo[1:0] != 2'b00);
      SZ_DWORD: bad = (lo != 3'b000);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_check
// Description : Combinational request decoder. Classifies the target region
//               (RAM at or above RAM_BASE, ROM below) and flags illegal
//               accesses: misaligned for the size, or a store into ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_check
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = 32'h0001_0000
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        we_i,
  output logic        is_ram_o,
  output logic        illegal_o
);

  // Region decode and legality check of the arbitration winner's request
  always_comb begin
    is_ram_o  = (addr_i >= RAM_BASE);
    illegal_o = misaligned(addr_i[2:0], size_i) | (we_i & ~is_ram_o);
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares the memory bus between the instruction-fetch port (F)
//               and the load/store port (D). Decodes ROM/RAM, rejects illegal
//               accesses, inserts per-region wait states and returns read
//               data through a req/gnt/done handshake.
//               Optional macro ARB_ROUND_ROBIN_EN: ties alternate between
//               ports via a last_grant register; otherwise D beats F.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  // fetch port
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_done,
  output logic [63:0] f_rdata,
  output logic        f_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        d_err,
  // memory bus
  output logic [31:0] mem_address,
  output logic [63:0] mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [63:0] mem_rdata,
  output logic        ram_cs,
  output logic        ram_write_en,
  output logic        ram_read,
  output logic [1:0]  ram_size,
  output logic        rom_cs,
  output logic        rom_oe,
  output logic        busy
);

  localparam logic [CNT_W-1:0] c_ROM_WAIT = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] c_RAM_WAIT = CNT_W'(RAM_WAIT);

  state_t           state_q,   state_d;
  port_t            port_q,    port_d;
  logic             is_ram_q,  is_ram_d;
  logic             we_q,      we_d;
  logic [1:0]       size_q,    size_d;
  logic             err_q,     err_d;
  logic             first_q,   first_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      addr_q,    addr_d;
  logic [63:0]      wdata_q,   wdata_d;
  logic [63:0]      f_rdata_q, f_rdata_d;
  logic [63:0]      d_rdata_q, d_rdata_d;

  // Winner of arbitration and its operands (only meaningful in IDLE)
  logic        w_sel_d;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic        w_we;
  logic [63:0] w_wdata;
  logic        w_is_ram;
  logic        w_illegal;
  logic [63:0] w_capture;

`ifdef ARB_ROUND_ROBIN_EN
  port_t last_grant_q, last_grant_d;

  // On a tie, serve the port that did not win last time
  assign w_sel_d = d_req & (~f_req | (last_grant_q == PORT_F));
`else
  // Fixed priority: D always beats F
  assign w_sel_d = d_req;
`endif

  // Fetches are always word-sized loads
  assign w_addr  = w_sel_d ? d_addr  : f_addr;
  assign w_size  = w_sel_d ? d_size  : SZ_WORD;
  assign w_we    = w_sel_d ? d_we    : 1'b0;
  assign w_wdata = w_sel_d ? d_wdata : 64'd0;

  mem_req_check #(
    .RAM_BASE (RAM_BASE)
  ) u_check (
    .addr_i    (w_addr),
    .size_i    (w_size),
    .we_i      (w_we),
    .is_ram_o  (w_is_ram),
    .illegal_o (w_illegal)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= PORT_F;
      is_ram_q  <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= 32'd0;
      wdata_q   <= 64'd0;
      f_rdata_q <= 64'd0;
      d_rdata_q <= 64'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_F;
`endif
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      is_ram_q  <= is_ram_d;
      we_q      <= we_d;
      size_q    <= size_d;
      err_q     <= err_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, count wait states in ACCESS
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    is_ram_d  = is_ram_q;
    we_d      = we_q;
    size_d    = size_q;
    err_d     = err_q;
    first_d   = 1'b0;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    w_capture = we_q ? 64'd0 : mem_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (f_req | d_req) begin
          port_d = w_sel_d ? PORT_D : PORT_F;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = w_sel_d ? PORT_D : PORT_F;
`endif
          if (w_illegal) begin
            // Rejected without touching the bus; bus registers keep old values
            err_d   = 1'b1;
            state_d = RESP;
            if (w_sel_d) d_rdata_d = 64'd0;
            else         f_rdata_d = 64'd0;
          end else begin
            err_d    = 1'b0;
            state_d  = ACCESS;
            first_d  = 1'b1;
            is_ram_d = w_is_ram;
            we_d     = w_we;
            size_d   = w_size;
            addr_d   = w_addr;
            wdata_d  = w_wdata;
            cnt_d    = w_is_ram ? c_RAM_WAIT : c_ROM_WAIT;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (port_q == PORT_D) d_rdata_d = w_capture;
          else                  f_rdata_d = w_capture;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  logic w_in_access;
  logic w_in_resp;
  logic w_gnt;

  assign w_in_access = (state_q == ACCESS);
  assign w_in_resp   = (state_q == RESP);
  assign w_gnt       = (w_in_access & first_q) | (w_in_resp & err_q);

  assign f_gnt   = w_gnt & (port_q == PORT_F);
  assign d_gnt   = w_gnt & (port_q == PORT_D);
  assign f_done  = w_in_resp & (port_q == PORT_F);
  assign d_done  = w_in_resp & (port_q == PORT_D);
  assign f_err   = f_done & err_q;
  assign d_err   = d_done & err_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;

  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign rom_cs       = w_in_access & ~is_ram_q;
  assign rom_oe       = w_in_access & ~is_ram_q;
  assign ram_cs       = w_in_access & is_ram_q;
  assign ram_read     = ram_cs & ~we_q;
  assign ram_write_en = ram_cs & we_q;
  assign mem_wdata_oe = ram_cs & we_q;
  assign ram_size     = ram_cs ? size_q : 2'b00;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter with the
//               default parameters (ROM_WAIT=1, RAM_WAIT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_done, f_err;
  logic [63:0] f_rdata;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt, d_done, d_err;
  logic [63:0] d_rdata;
  logic [31:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_wdata_oe;
  logic [63:0] mem_rdata;
  logic        ram_cs, ram_write_en, ram_read;
  logic [1:0]  ram_size;
  logic        rom_cs, rom_oe, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .f_req        (f_req),
    .f_addr       (f_addr),
    .f_gnt        (f_gnt),
    .f_done       (f_done),
    .f_rdata      (f_rdata),
    .f_err        (f_err),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_size       (d_size),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_done       (d_done),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .mem_rdata    (mem_rdata),
    .ram_cs       (ram_cs),
    .ram_write_en (ram_write_en),
    .ram_read     (ram_read),
    .ram_size     (ram_size),
    .rom_cs       (rom_cs),
    .rom_oe       (rom_oe),
    .busy         (busy)
  );

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; f_req = 1'b0; f_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_size = SZ_BYTE; d_addr = 32'd0; d_wdata = 64'd0;
    mem_rdata = 64'h1122_3344_5566_7788;

    // Reset state
    tick; tick;
    check("rst busy", busy, 1'b0);
    check("rst f_done", f_done, 1'b0);
    check("rst d_done", d_done, 1'b0);
    check("rst mem_address", mem_address, 32'd0);
    check("rst ram_cs", ram_cs, 1'b0);
    check("rst rom_cs", rom_cs, 1'b0);
    check("rst f_rdata", f_rdata, 64'd0);
    reset = 1'b0;
    tick;

    // F read from ROM 0x100: gnt cycle 1, rom strobes cycles 1-2, done cycle 3
    f_req = 1'b1; f_addr = 32'h100;
    tick;
    check("fr gnt", f_gnt, 1'b1);
    check("fr d_gnt", d_gnt, 1'b0);
    check("fr rom_cs c1", rom_cs, 1'b1);
    check("fr rom_oe c1", rom_oe, 1'b1);
    check("fr ram_cs c1", ram_cs, 1'b0);
    check("fr addr", mem_address, 32'h100);
    check("fr busy", busy, 1'b1);
    tick;
    check("fr gnt c2", f_gnt, 1'b0);
    check("fr rom_cs c2", rom_cs, 1'b1);
    check("fr done c2", f_done, 1'b0);
    tick;
    check("fr done c3", f_done, 1'b1);
    check("fr rdata", f_rdata, 64'h1122_3344_5566_7788);
    check("fr err", f_err, 1'b0);
    check("fr rom_cs c3", rom_cs, 1'b0);
    f_req = 1'b0;
    tick;
    check("fr idle done", f_done, 1'b0);
    check("fr idle busy", busy, 1'b0);
    check("fr rdata hold", f_rdata, 64'h1122_3344_5566_7788);

    // D dword store to RAM 0x10008: strobes cycles 1-3, done cycle 4
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_DWORD; d_addr = 32'h0001_0008;
    d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick;
    check("ds gnt", d_gnt, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick;
      check("ds ram_cs", ram_cs, 1'b1);
      check("ds ram_write_en", ram_write_en, 1'b1);
      check("ds wdata_oe", mem_wdata_oe, 1'b1);
      check("ds ram_read", ram_read, 1'b0);
      check("ds ram_size", ram_size, 2'b11);
      check("ds wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      check("ds done early", d_done, 1'b0);
    end
    tick;
    check("ds done", d_done, 1'b1);
    check("ds err", d_err, 1'b0);
    check("ds rdata", d_rdata, 64'd0);
    check("ds ram_cs off", ram_cs, 1'b0);
    check("ds oe off", mem_wdata_oe, 1'b0);
    d_req = 1'b0; d_we = 1'b0;
    tick;

    // Tie: D load from RAM wins, F (ROM) served in the IDLE after it
    f_req = 1'b1; f_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = 32'h0001_0010;
    mem_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
    tick;
    check("tie d_gnt", d_gnt, 1'b1);
    check("tie f_gnt", f_gnt, 1'b0);
    check("tie ram_read", ram_read, 1'b1);
    tick; tick;
    check("tie no done c3", d_done, 1'b0);
    tick;
    check("tie d_done c4", d_done, 1'b1);
    check("tie f_done c4", f_done, 1'b0);
    check("tie d_rdata", d_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
    d_req = 1'b0;
    tick;
    check("tie idle busy", busy, 1'b0);
    check("tie idle f_gnt", f_gnt, 1'b0);
    mem_rdata = 64'h0000_0000_0000_0200;
    tick;
    check("tie f_gnt c6", f_gnt, 1'b1);
    check("tie f addr", mem_address, 32'h200);
    tick; tick;
    check("tie f_done c8", f_done, 1'b1);
    check("tie f_rdata", f_rdata, 64'h0000_0000_0000_0200);
    f_req = 1'b0;
    tick;

    // Misaligned word load: error done in cycle 1, no strobes
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = 32'h0001_0002;
    tick;
    check("mis d_done", d_done, 1'b1);
    check("mis d_err", d_err, 1'b1);
    check("mis d_gnt", d_gnt, 1'b1);
    check("mis ram_cs", ram_cs, 1'b0);
    check("mis rom_cs", rom_cs, 1'b0);
    d_req = 1'b0;
    tick;
    check("mis idle err", d_err, 1'b0);

    // Store into ROM region: error done in cycle 1, no strobes
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_DWORD; d_addr = 32'h40;
    tick;
    check("romst d_done", d_done, 1'b1);
    check("romst d_err", d_err, 1'b1);
    check("romst rom_cs", rom_cs, 1'b0);
    check("romst ram_cs", ram_cs, 1'b0);
    check("romst wdata_oe", mem_wdata_oe, 1'b0);
    d_req = 1'b0; d_we = 1'b0;
    tick;

    // Reset during the 2nd ACCESS cycle of a RAM load abandons it
    d_req = 1'b1; d_size = SZ_WORD; d_addr = 32'h0001_0020;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick;
    check("ra c1 ram_cs", ram_cs, 1'b1);
    tick;
    check("ra c2 ram_cs", ram_cs, 1'b1);
    reset = 1'b1;
    tick;
    check("ra busy", busy, 1'b0);
    check("ra ram_cs", ram_cs, 1'b0);
    check("ra d_done", d_done, 1'b0);
    check("ra mem_address", mem_address, 32'd0);
    check("ra d_rdata", d_rdata, 64'd0);
    reset = 1'b0; d_req = 1'b0;
    tick;
    check("ra no done c4", d_done, 1'b0);
    tick;
    check("ra no done c5", d_done, 1'b0);
    // New request after reset completes normally
    d_req = 1'b1;
    tick;
    check("ra2 gnt", d_gnt, 1'b1);
    tick; tick; tick;
    check("ra2 done", d_done, 1'b1);
    check("ra2 rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
    d_req = 1'b0;
    tick;

    // Back-to-back F fetches with req held: one request every WAIT+3 cycles
    f_req = 1'b1; f_addr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("b2b gnt", f_gnt, 1'b1);
      check("b2b addr", mem_address, 32'h400 + 32'(8 * k));
      mem_rdata = 64'hB0B0_0000_0000_0000 | 64'(k);
      tick;
      check("b2b early done", f_done, 1'b0);
      tick;
      check("b2b done", f_done, 1'b1);
      check("b2b rdata", f_rdata, 64'hB0B0_0000_0000_0000 | 64'(k));
      if (k < 2) f_addr = f_addr + 32'd8;
      else       f_req = 1'b0;
      tick;
      check("b2b idle busy", busy, 1'b0);
      check("b2b idle done", f_done, 1'b0);
    end
    tick;
    check("b2b final idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
